// File: rtl/bus_master.sv
// bus_master
//
// Single-outstanding 68000-style bus initiator. Converts one valid/ready
// request from an on-chip agent into one asynchronous bus cycle:
// ADDR (address/rw/data set-up), STROBE (as/uds/lds asserted until dtack,
// berr or watchdog), RELEASE (strobes dropped, one-cycle response pulse).
//
// Optional feature macro: BUS_MASTER_WATCHDOG_EN
//   defined   -> STROBE is aborted after TIMEOUT cycles without
//                acknowledge and the response carries o_resp_timeout=1.
//   undefined -> no watchdog; STROBE waits indefinitely for dtack or berr,
//                o_resp_timeout is tied low and TIMEOUT has no effect.
//
// Parameters:
//   ADDR_W   word address width (A23..A1)
//   TIMEOUT  STROBE cycles without acknowledge before abort (>= 1)
//
// Ports (all strobes, dtack and berr active-high):
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_req_valid         request present
//   o_req_ready         high only in IDLE (and not in reset)
//   i_req_write         1 = write, 0 = read
//   i_req_addr          word address
//   i_req_wdata         write data
//   i_req_be            byte enables, [1] = upper (uds), [0] = lower (lds)
//   o_resp_valid        one-cycle completion pulse
//   o_resp_rdata        read data, updated only on successful reads
//   o_resp_berr         cycle ended by berr or illegal request
//   o_resp_timeout      cycle ended by watchdog
//   o_bus_addr          bus address
//   o_bus_rw            1 = read
//   o_bus_as/uds/lds    address and data strobes
//   o_bus_dout          write data
//   o_bus_dout_en       data bus drive enable
//   i_bus_din           read data
//   i_dtack, i_berr     responder acknowledge and bus error

module bus_master #(
  parameter int ADDR_W  = 23,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [15:0]       i_req_wdata,
  input  logic [1:0]        i_req_be,
  output logic              o_resp_valid,
  output logic [15:0]       o_resp_rdata,
  output logic              o_resp_berr,
  output logic              o_resp_timeout,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic              o_bus_rw,
  output logic              o_bus_as,
  output logic              o_bus_uds,
  output logic              o_bus_lds,
  output logic [15:0]       o_bus_dout,
  output logic              o_bus_dout_en,
  input  logic [15:0]       i_bus_din,
  input  logic              i_dtack,
  input  logic              i_berr
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ADDR    = 2'd1,
    S_STROBE  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_bus_addr;
  logic              r_bus_rw;
  logic              r_bus_as;
  logic              r_bus_uds;
  logic              r_bus_lds;
  logic [15:0]       r_bus_dout;
  logic              r_bus_dout_en;
  logic [1:0]        r_be;
  logic              r_resp_valid;
  logic              r_resp_berr;
  logic [15:0]       r_resp_rdata;
  logic              w_timeout_hit;

  // A TIMEOUT below 1 has no meaning; this block exists only so an illegal
  // value is visible in the elaborated hierarchy.
  if (TIMEOUT < 1) begin : g_timeout_out_of_range
  end

`ifdef BUS_MASTER_WATCHDOG_EN
  localparam int WDOG_W = $clog2(TIMEOUT + 1);

  logic [WDOG_W-1:0] r_wdog;
  logic [WDOG_W-1:0] w_wdog_inc;
  logic              r_resp_timeout;

  // The counter holds (STROBE cycles already completed), so the abort is
  // decided in the TIMEOUT-th STROBE cycle, when the incremented value
  // reaches TIMEOUT.
  assign w_wdog_inc    = r_wdog + 1'b1;
  assign w_timeout_hit = (w_wdog_inc == WDOG_W'(TIMEOUT));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wdog <= '0;
    end else if (r_state == S_ADDR) begin
      r_wdog <= '0;
    end else if (r_state == S_STROBE) begin
      r_wdog <= w_wdog_inc;
    end
  end

  // Timeout only when neither berr nor dtack terminated the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_resp_timeout <= 1'b0;
    end else begin
      r_resp_timeout <= (r_state == S_STROBE) && !i_berr && !i_dtack && w_timeout_hit;
    end
  end

  assign o_resp_timeout = r_resp_timeout;
`else
  assign w_timeout_hit  = 1'b0;
  assign o_resp_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_bus_addr    <= '0;
      r_bus_rw      <= 1'b1;
      r_bus_as      <= 1'b0;
      r_bus_uds     <= 1'b0;
      r_bus_lds     <= 1'b0;
      r_bus_dout    <= '0;
      r_bus_dout_en <= 1'b0;
      r_be          <= 2'b00;
      r_resp_valid  <= 1'b0;
      r_resp_berr   <= 1'b0;
      r_resp_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            if (i_req_be == 2'b00) begin
              // Illegal request: complete with an error without touching
              // the bus at all (address and rw keep their previous values).
              r_state      <= S_RELEASE;
              r_resp_valid <= 1'b1;
              r_resp_berr  <= 1'b1;
            end else begin
              r_state       <= S_ADDR;
              r_bus_addr    <= i_req_addr;
              r_bus_rw      <= ~i_req_write;
              r_be          <= i_req_be;
              r_bus_dout_en <= i_req_write;
              if (i_req_write) begin
                r_bus_dout <= i_req_wdata;
              end
            end
          end
        end

        S_ADDR: begin
          // Address set-up cycle; acknowledges are deliberately ignored.
          r_state   <= S_STROBE;
          r_bus_as  <= 1'b1;
          r_bus_uds <= r_be[1];
          r_bus_lds <= r_be[0];
        end

        S_STROBE: begin
          // Priority: berr, then dtack, then watchdog.
          if (i_berr || i_dtack || w_timeout_hit) begin
            r_state      <= S_RELEASE;
            r_bus_as     <= 1'b0;
            r_bus_uds    <= 1'b0;
            r_bus_lds    <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_berr  <= i_berr;
            if (!i_berr && i_dtack && r_bus_rw) begin
              r_resp_rdata <= i_bus_din;
            end
          end
        end

        S_RELEASE: begin
          // Address and dout stay held; the bus returns to its idle
          // direction (read, not driving) as we go back to IDLE.
          r_state       <= S_IDLE;
          r_resp_valid  <= 1'b0;
          r_resp_berr   <= 1'b0;
          r_bus_dout_en <= 1'b0;
          r_bus_rw      <= 1'b1;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready   = (r_state == S_IDLE) && !i_reset;
  assign o_resp_valid  = r_resp_valid;
  assign o_resp_rdata  = r_resp_rdata;
  assign o_resp_berr   = r_resp_berr;
  assign o_bus_addr    = r_bus_addr;
  assign o_bus_rw      = r_bus_rw;
  assign o_bus_as      = r_bus_as;
  assign o_bus_uds     = r_bus_uds;
  assign o_bus_lds     = r_bus_lds;
  assign o_bus_dout    = r_bus_dout;
  assign o_bus_dout_en = r_bus_dout_en;

endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master
//
// Self-checking bench for bus_master. A table of request records (stimulus
// plus expected response) is replayed through a reactive responder model;
// expected responses are queued when a request is driven and popped when
// the DUT raises o_resp_valid. Hand-written sequences cover reset state,
// the non-watchdog hang and reset in the middle of a cycle.

`timescale 1ns/1ps

module tb_bus_master;

  localparam int ADDR_W  = 23;
  localparam int TIMEOUT = 4;
  localparam int MAX_CYC = 40;

  typedef enum int {M_ACK, M_BERR, M_BOTH, M_NONE} mode_t;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic [1:0]        be;
    logic [15:0]       din;
    bit                hold;      // dtack held high for the whole transaction
    int                waits;     // wait states before the acknowledge
    mode_t             mode;
    int                exp_lat;   // cycles from accept edge to resp_valid
    int                exp_as;    // cycles with bus_as high
    logic [15:0]       exp_rdata;
    bit                exp_berr;
    bit                exp_to;
  } vec_t;

  typedef struct {
    int          lat;
    int          as_cyc;
    logic [15:0] rdata;
    bit          berr;
    bit          to;
  } exp_t;

  logic              clk = 1'b0;
  logic              i_reset;
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_write;
  logic [ADDR_W-1:0] i_req_addr;
  logic [15:0]       i_req_wdata;
  logic [1:0]        i_req_be;
  logic              o_resp_valid;
  logic [15:0]       o_resp_rdata;
  logic              o_resp_berr;
  logic              o_resp_timeout;
  logic [ADDR_W-1:0] o_bus_addr;
  logic              o_bus_rw;
  logic              o_bus_as;
  logic              o_bus_uds;
  logic              o_bus_lds;
  logic [15:0]       o_bus_dout;
  logic              o_bus_dout_en;
  logic [15:0]       i_bus_din;
  logic              i_dtack;
  logic              i_berr;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_vectors     = 0;
  int   n_checks      = 0;
  int   n_miscompares = 0;
  logic [ADDR_W-1:0] model_addr = '0;

  always #5 clk = ~clk;

  bus_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_write    (i_req_write),
    .i_req_addr     (i_req_addr),
    .i_req_wdata    (i_req_wdata),
    .i_req_be       (i_req_be),
    .o_resp_valid   (o_resp_valid),
    .o_resp_rdata   (o_resp_rdata),
    .o_resp_berr    (o_resp_berr),
    .o_resp_timeout (o_resp_timeout),
    .o_bus_addr     (o_bus_addr),
    .o_bus_rw       (o_bus_rw),
    .o_bus_as       (o_bus_as),
    .o_bus_uds      (o_bus_uds),
    .o_bus_lds      (o_bus_lds),
    .o_bus_dout     (o_bus_dout),
    .o_bus_dout_en  (o_bus_dout_en),
    .i_bus_din      (i_bus_din),
    .i_dtack        (i_dtack),
    .i_berr         (i_berr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_miscompares++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic add_vec(input logic wr, input logic [ADDR_W-1:0] addr, input logic [15:0] wdata,
                         input logic [1:0] be, input logic [15:0] din, input bit hold,
                         input int waits, input mode_t mode, input int exp_lat, input int exp_as,
                         input logic [15:0] exp_rdata, input bit exp_berr, input bit exp_to);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be; v.din = din; v.hold = hold;
    v.waits = waits; v.mode = mode; v.exp_lat = exp_lat; v.exp_as = exp_as;
    v.exp_rdata = exp_rdata; v.exp_berr = exp_berr; v.exp_to = exp_to;
    vecs.push_back(v);
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic run_vec(input int idx, input vec_t v);
    int   cyc;
    int   as_cnt;
    bit   done;
    bit   exp_rw;
    exp_t e;
    exp_rw = !v.wr;
    chk("idle_ready", o_req_ready, 1);
    chk("idle_resp_valid", o_resp_valid, 0);
    chk("idle_as", o_bus_as, 0);
    chk("idle_dout_en", o_bus_dout_en, 0);
    chk("idle_rw", o_bus_rw, 1);

    i_req_valid = 1'b1;
    i_req_write = v.wr;
    i_req_addr  = v.addr;
    i_req_wdata = v.wdata;
    i_req_be    = v.be;
    i_bus_din   = v.din;
    i_dtack     = v.hold;
    i_berr      = 1'b0;
    e.lat = v.exp_lat; e.as_cyc = v.exp_as; e.rdata = v.exp_rdata;
    e.berr = v.exp_berr; e.to = v.exp_to;
    exp_q.push_back(e);

    @(negedge clk);
    // Request is consumed at the accept edge; scramble it to prove latching.
    i_req_valid = 1'b0;
    i_req_write = ~v.wr;
    i_req_addr  = ~v.addr;
    i_req_wdata = ~v.wdata;
    i_req_be    = ~v.be;
    cyc    = 1;
    as_cnt = 0;
    done   = 0;
    while (!done && cyc <= MAX_CYC) begin
      if (o_bus_as) as_cnt++;
      if (v.be == 2'b00) begin
        chk("illegal_as", o_bus_as, 0);
        chk("illegal_uds", o_bus_uds, 0);
        chk("illegal_lds", o_bus_lds, 0);
        chk("illegal_addr_held", o_bus_addr, model_addr);
        chk("illegal_rw_held", o_bus_rw, 1);
        chk("illegal_dout_en", o_bus_dout_en, 0);
      end else begin
        chk("bus_addr", o_bus_addr, v.addr);
        chk("bus_rw", o_bus_rw, exp_rw);
        chk("bus_dout_en", o_bus_dout_en, v.wr);
        if (v.wr) chk("bus_dout", o_bus_dout, v.wdata);
        chk("bus_uds", o_bus_uds, o_bus_as ? v.be[1] : 1'b0);
        chk("bus_lds", o_bus_lds, o_bus_as ? v.be[0] : 1'b0);
      end
      if (o_resp_valid) begin
        e = exp_q.pop_front();
        chk("resp_latency", cyc, e.lat);
        chk("as_cycles", as_cnt, e.as_cyc);
        chk("resp_rdata", o_resp_rdata, e.rdata);
        chk("resp_berr", o_resp_berr, e.berr);
        chk("resp_timeout", o_resp_timeout, e.to);
        done = 1;
      end else begin
        if (o_bus_as && as_cnt == v.waits + 1) begin
          case (v.mode)
            M_ACK:   begin i_dtack = 1'b1; i_berr = 1'b0; end
            M_BERR:  begin i_dtack = 1'b0; i_berr = 1'b1; end
            M_BOTH:  begin i_dtack = 1'b1; i_berr = 1'b1; end
            default: begin i_dtack = v.hold; i_berr = 1'b0; end
          endcase
        end else begin
          i_dtack = v.hold;
          i_berr  = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) begin
      n_checks++;
      n_miscompares++;
      $display("FAIL vec%0d_no_resp: actual=none required=resp_valid within %0d cycles", idx, MAX_CYC);
      void'(exp_q.pop_front());
    end
    $display("vec %0d: wr=%0b addr=%h be=%b -> lat=%0d as=%0d rdata=%h berr=%0b to=%0b",
             idx, v.wr, v.addr, v.be, cyc, as_cnt, o_resp_rdata, o_resp_berr, o_resp_timeout);
    i_dtack = 1'b0;
    i_berr  = 1'b0;
    @(negedge clk);
    if (v.be != 2'b00) model_addr = v.addr;
    n_vectors++;
  endtask

  task automatic reset_mid_cycle();
    i_req_valid = 1'b1; i_req_write = 1'b1; i_req_addr = 23'h000300;
    i_req_wdata = 16'hCAFE; i_req_be = 2'b11; i_dtack = 1'b0; i_berr = 1'b0;
    @(negedge clk);                        // ADDR
    i_req_valid = 1'b0;
    @(negedge clk);                        // STROBE 1
    chk("rst_mid_as_s1", o_bus_as, 1);
    @(negedge clk);                        // STROBE 2
    chk("rst_mid_as_s2", o_bus_as, 1);
    i_reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_as", o_bus_as, 0);
    chk("rst_mid_uds", o_bus_uds, 0);
    chk("rst_mid_lds", o_bus_lds, 0);
    chk("rst_mid_dout_en", o_bus_dout_en, 0);
    chk("rst_mid_resp_valid", o_resp_valid, 0);
    chk("rst_mid_ready_in_reset", o_req_ready, 0);
    i_reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_mid_no_resp", o_resp_valid, 0);
      chk("rst_mid_ready", o_req_ready, 1);
    end
    chk("rst_mid_rdata_reset", o_resp_rdata, 0);
    $display("reset mid-cycle: as=%0b dout_en=%0b ready=%0b", o_bus_as, o_bus_dout_en, o_req_ready);
    n_vectors++;
  endtask

`ifndef BUS_MASTER_WATCHDOG_EN
  task automatic hang_without_watchdog();
    int as_cyc;
    int resp_cyc;
    i_req_valid = 1'b1; i_req_write = 1'b0; i_req_addr = 23'h000400;
    i_req_be = 2'b11; i_dtack = 1'b0; i_berr = 1'b0;
    @(negedge clk);                        // ADDR
    i_req_valid = 1'b0;
    as_cyc   = 0;
    resp_cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (o_bus_as) as_cyc++;
      if (o_resp_valid) resp_cyc++;
    end
    chk("nowdog_as_cycles", as_cyc, 1000);
    chk("nowdog_resp_valid", resp_cyc, 0);
    $display("no watchdog: as high %0d of 1000 cycles, resp_valid %0d times", as_cyc, resp_cyc);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    n_vectors++;
  endtask
`endif

  initial begin
    i_reset = 1'b1; i_req_valid = 1'b0; i_req_write = 1'b0; i_req_addr = '0;
    i_req_wdata = '0; i_req_be = 2'b00; i_bus_din = '0; i_dtack = 1'b0; i_berr = 1'b0;

    //      wr    addr          wdata     be     din       hold waits mode    lat as rdata     berr to
    add_vec(1'b0, 23'h000100, 16'h0000, 2'b11, 16'hBEEF, 1, 0,  M_ACK,  3, 1, 16'hBEEF, 0, 0);
    add_vec(1'b1, 23'h000200, 16'h1234, 2'b01, 16'hDEAD, 0, 2,  M_ACK,  5, 3, 16'hBEEF, 0, 0);
    add_vec(1'b0, 23'h000204, 16'h0000, 2'b11, 16'h5555, 0, 0,  M_BOTH, 3, 1, 16'hBEEF, 1, 0);
    add_vec(1'b0, 23'h7FFFFF, 16'h0000, 2'b10, 16'hA5A5, 0, 1,  M_ACK,  4, 2, 16'hA5A5, 0, 0);
    add_vec(1'b1, 23'h000555, 16'h9999, 2'b00, 16'h0000, 0, 0,  M_ACK,  1, 0, 16'hA5A5, 1, 0);
    add_vec(1'b0, 23'h012345, 16'h0000, 2'b01, 16'h0F0F, 0, 3,  M_ACK,  6, 4, 16'h0F0F, 0, 0);
    add_vec(1'b1, 23'h000ABC, 16'h7E57, 2'b11, 16'h1111, 0, 1,  M_BERR, 4, 2, 16'h0F0F, 1, 0);
`ifdef BUS_MASTER_WATCHDOG_EN
    add_vec(1'b0, 23'h000400, 16'h0000, 2'b11, 16'h2222, 0, 999, M_NONE, 6, 4, 16'h0F0F, 0, 1);
`endif

    repeat (3) @(negedge clk);
    chk("rst_ready_in_reset", o_req_ready, 0);
    chk("rst_as", o_bus_as, 0);
    chk("rst_uds", o_bus_uds, 0);
    chk("rst_lds", o_bus_lds, 0);
    chk("rst_rw", o_bus_rw, 1);
    chk("rst_addr", o_bus_addr, 0);
    chk("rst_dout", o_bus_dout, 0);
    chk("rst_dout_en", o_bus_dout_en, 0);
    chk("rst_resp_valid", o_resp_valid, 0);
    chk("rst_rdata", o_resp_rdata, 0);
    chk("rst_berr", o_resp_berr, 0);
    chk("rst_timeout", o_resp_timeout, 0);
    i_reset = 1'b0;
    @(negedge clk);
    chk("rst_ready_after", o_req_ready, 1);
    $display("reset: ready=%0b as=%0b rw=%0b addr=%h", o_req_ready, o_bus_as, o_bus_rw, o_bus_addr);

    foreach (vecs[i]) run_vec(i, vecs[i]);

`ifndef BUS_MASTER_WATCHDOG_EN
    hang_without_watchdog();
`endif
    reset_mid_cycle();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual=still running required=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
